// File: rtl/dac_serial_rx_pkg.sv
// Shared constants for the DAC serial responder: frame layout, command codes,
// FSM state encoding and software-control bit positions.
package dac_serial_rx_pkg;

    localparam int FRAME_NBIT = 24;
    localparam int CNT_NBIT   = 5;
    localparam logic [CNT_NBIT-1:0] FRAME_CNT = CNT_NBIT'(FRAME_NBIT);

    typedef enum logic [2:0] {
        CMD_NOP    = 3'b000,
        CMD_RG     = 3'b001,
        CMD_CTRL   = 3'b010,
        CMD_CLR    = 3'b011,
        CMD_SWCTRL = 3'b100
    } cmd_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } state_e;

    localparam int SW_RESET_BIT = 2;
    localparam int SW_CLR_BIT   = 1;
    localparam int SW_LDAC_BIT  = 0;

endpackage

// File: rtl/dac_serial_rx_sync_edge.sv
// N-stage synchronizer for one asynchronous input, with rise/fall pulses
// derived from the synchronized level.
module dac_serial_rx_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // NOTE: non-blocking assignments let every flop sample the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/dac_serial_rx.sv
// Receiving end of the 24-bit SYNC/SCLK/SDO DAC link: decodes frames into an
// AD5791-style register file, drives the latched DAC word and shifts readback on sdo.
module dac_serial_rx
    import dac_serial_rx_pkg::*;
#(
    parameter int DATA_NBIT   = 20,
    parameter int CMD_NBIT    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 sync,
    input  logic                 sdi,
    input  logic                 ldac,
    input  logic                 clr,
    output logic                 sdo,
    output logic [DATA_NBIT-1:0] dac_reg,
    output logic [DATA_NBIT-1:0] ctrl_reg,
    output logic [DATA_NBIT-1:0] clr_reg,
    output logic [DATA_NBIT-1:0] dac_out,
    output logic                 dac_out_valid,
    output logic                 frame_err
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic sync_lvl, sync_rise, sync_fall;
    logic sdi_s, sdi_rise, sdi_fall;
    logic ldac_lvl, ldac_rise, ldac_fall;
    logic clr_s, clr_rise, clr_fall;

    dac_serial_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(mclk), .rst(rst), .d(sclk), .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    dac_serial_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(mclk), .rst(rst), .d(sync), .q(sync_lvl), .rise(sync_rise), .fall(sync_fall));
    dac_serial_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sdi (
        .clk(mclk), .rst(rst), .d(sdi), .q(sdi_s), .rise(sdi_rise), .fall(sdi_fall));
    dac_serial_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_ldac (
        .clk(mclk), .rst(rst), .d(ldac), .q(ldac_lvl), .rise(ldac_rise), .fall(ldac_fall));
    dac_serial_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_clr (
        .clk(mclk), .rst(rst), .d(clr), .q(clr_s), .rise(clr_rise), .fall(clr_fall));

    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, sync_lvl, sdi_rise, sdi_fall, ldac_lvl, ldac_fall, clr_fall};

    state_e                state_q, state_d;
    logic [CNT_NBIT-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_NBIT-1:0] shift_q, shift_d;
    logic [FRAME_NBIT-1:0] rb_q, rb_d;
    logic [DATA_NBIT-1:0]  dac_reg_q, dac_reg_d, ctrl_reg_q, ctrl_reg_d;
    logic [DATA_NBIT-1:0]  clr_reg_q, clr_reg_d, dac_out_q, dac_out_d;
    logic                  valid_q, valid_d, err_q, err_d, pend_q, pend_d;

    logic                  frame_rw;
    logic [CMD_NBIT-1:0]   frame_cmd;
    logic [DATA_NBIT-1:0]  frame_data;

    assign frame_rw   = shift_q[FRAME_NBIT-1];
    assign frame_cmd  = shift_q[FRAME_NBIT-2 -: CMD_NBIT];
    assign frame_data = shift_q[DATA_NBIT-1:0];

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rb_d       = rb_q;
        dac_reg_d  = dac_reg_q;
        ctrl_reg_d = ctrl_reg_q;
        clr_reg_d  = clr_reg_q;
        dac_out_d  = dac_out_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        pend_d     = 1'b0;

        // Pin-driven output update; clr level wins over an ldac edge.
        if (clr_s) begin
            dac_out_d = clr_reg_q;
            valid_d   = clr_rise;
        end else if (ldac_rise) begin
            dac_out_d = dac_reg_q;
            valid_d   = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (sync_rise || pend_q) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (sclk_fall) begin
                    shift_d = {shift_q[FRAME_NBIT-2:0], sdi_s};
                    if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (sclk_rise) rb_d = {rb_q[FRAME_NBIT-2:0], 1'b0};
                if (sync_fall) begin
                    if (bit_cnt_q == FRAME_CNT) begin
                        state_d = ST_DECODE;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                pend_d  = sync_rise;
                if (frame_rw == RW_WRITE) begin
                    rb_d = '0;
                    case (cmd_e'(frame_cmd))
                        CMD_RG:   dac_reg_d  = frame_data;
                        CMD_CTRL: ctrl_reg_d = frame_data;
                        CMD_CLR:  clr_reg_d  = frame_data;
                        CMD_SWCTRL: begin
                            if (frame_data[SW_RESET_BIT]) begin
                                dac_reg_d  = '0;
                                ctrl_reg_d = '0;
                                clr_reg_d  = '0;
                                dac_out_d  = '0;
                                valid_d    = 1'b1;
                            end else if (frame_data[SW_CLR_BIT]) begin
                                dac_out_d = clr_reg_q;
                                valid_d   = 1'b1;
                            end else if (frame_data[SW_LDAC_BIT]) begin
                                dac_out_d = dac_reg_q;
                                valid_d   = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    case (cmd_e'(frame_cmd))
                        CMD_RG:   rb_d = {RW_READ, frame_cmd, dac_reg_q};
                        CMD_CTRL: rb_d = {RW_READ, frame_cmd, ctrl_reg_q};
                        CMD_CLR:  rb_d = {RW_READ, frame_cmd, clr_reg_q};
                        default:  rb_d = '0;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the register file is a handful of flops, so it is reset like all other state.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rb_q       <= '0;
            dac_reg_q  <= '0;
            ctrl_reg_q <= '0;
            clr_reg_q  <= '0;
            dac_out_q  <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rb_q       <= rb_d;
            dac_reg_q  <= dac_reg_d;
            ctrl_reg_q <= ctrl_reg_d;
            clr_reg_q  <= clr_reg_d;
            dac_out_q  <= dac_out_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
        end
    end

    assign sdo           = rb_q[FRAME_NBIT-1];
    assign dac_reg       = dac_reg_q;
    assign ctrl_reg      = ctrl_reg_q;
    assign clr_reg       = clr_reg_q;
    assign dac_out       = dac_out_q;
    assign dac_out_valid = valid_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_dac_serial_rx.sv
// Directed bench for dac_serial_rx: drives SYNC/SCLK/SDI frames and LDAC/CLR
// pins and compares registers, dac_out, sdo readback and pulse counts.
module tb_dac_serial_rx;

    logic        mclk = 1'b0;
    logic        rst  = 1'b1;
    logic        sclk = 1'b1;
    logic        sync = 1'b0;
    logic        sdi  = 1'b0;
    logic        ldac = 1'b0;
    logic        clr  = 1'b0;
    logic        sdo;
    logic [19:0] dac_reg, ctrl_reg, clr_reg, dac_out;
    logic        dac_out_valid, frame_err;

    int n_cmp = 0;
    int n_mis = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    always #5 mclk = ~mclk;

    dac_serial_rx dut (
        .mclk(mclk), .rst(rst), .sclk(sclk), .sync(sync), .sdi(sdi),
        .ldac(ldac), .clr(clr), .sdo(sdo), .dac_reg(dac_reg),
        .ctrl_reg(ctrl_reg), .clr_reg(clr_reg), .dac_out(dac_out),
        .dac_out_valid(dac_out_valid), .frame_err(frame_err)
    );

    always @(negedge mclk) begin
        if (dac_out_valid) valid_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge mclk);
    endtask

    // Raises sync and clocks n bits of val MSB first; sdo is captured just before each sclk fall.
    task automatic send_bits(input logic [31:0] val, input int n, output logic [31:0] cap);
        cap  = '0;
        sync = 1'b1;
        wait_cyc(6);
        for (int i = n - 1; i >= 0; i--) begin
            sdi = val[i];
            wait_cyc(3);
            cap  = {cap[30:0], sdo};
            sclk = 1'b0;
            wait_cyc(6);
            sclk = 1'b1;
            wait_cyc(3);
        end
    endtask

    task automatic end_frame();
        sync = 1'b0;
        wait_cyc(8);
    endtask

    task automatic write_frame(input logic [23:0] f);
        logic [31:0] cap;
        send_bits({8'h00, f}, 24, cap);
        end_frame();
    endtask

    task automatic test_reset();
        wait_cyc(3);
        n_cmp++; if (dac_reg !== 20'h0) begin n_mis++; $display("FAIL reset_dac_reg: got %h expected %h", dac_reg, 20'h0); end
        n_cmp++; if (ctrl_reg !== 20'h0) begin n_mis++; $display("FAIL reset_ctrl_reg: got %h expected %h", ctrl_reg, 20'h0); end
        n_cmp++; if (clr_reg !== 20'h0) begin n_mis++; $display("FAIL reset_clr_reg: got %h expected %h", clr_reg, 20'h0); end
        n_cmp++; if (dac_out !== 20'h0) begin n_mis++; $display("FAIL reset_dac_out: got %h expected %h", dac_out, 20'h0); end
        n_cmp++; if ({sdo, dac_out_valid, frame_err} !== 3'b000) begin n_mis++; $display("FAIL reset_flags: got %b expected %b", {sdo, dac_out_valid, frame_err}, 3'b000); end
        rst = 1'b0;
        wait_cyc(6);
        n_cmp++; if (valid_cnt + err_cnt !== 0) begin n_mis++; $display("FAIL reset_pulses: got %0d expected %0d", valid_cnt + err_cnt, 0); end
    endtask

    task automatic test_write_ldac();
        logic [31:0] cap;
        int v0;
        send_bits(32'h1ABCDE, 24, cap);
        sync = 1'b0;
        wait_cyc(3);
        n_cmp++; if (dac_reg !== 20'h00000) begin n_mis++; $display("FAIL write_latency_early: got %h expected %h", dac_reg, 20'h00000); end
        wait_cyc(1);
        n_cmp++; if (dac_reg !== 20'hABCDE) begin n_mis++; $display("FAIL write_dac_reg: got %h expected %h", dac_reg, 20'hABCDE); end
        wait_cyc(6);
        v0   = valid_cnt;
        ldac = 1'b1;
        wait_cyc(2);
        n_cmp++; if (dac_out !== 20'h00000) begin n_mis++; $display("FAIL ldac_latency_early: got %h expected %h", dac_out, 20'h00000); end
        wait_cyc(1);
        n_cmp++; if (dac_out !== 20'hABCDE) begin n_mis++; $display("FAIL ldac_dac_out: got %h expected %h", dac_out, 20'hABCDE); end
        wait_cyc(4);
        ldac = 1'b0;
        wait_cyc(6);
        n_cmp++; if (valid_cnt - v0 !== 1) begin n_mis++; $display("FAIL ldac_valid_pulses: got %0d expected %0d", valid_cnt - v0, 1); end
    endtask

    task automatic test_clr();
        int v0;
        write_frame(24'h312345);
        n_cmp++; if (clr_reg !== 20'h12345) begin n_mis++; $display("FAIL clr_reg_write: got %h expected %h", clr_reg, 20'h12345); end
        v0   = valid_cnt;
        clr  = 1'b1;
        ldac = 1'b1;
        wait_cyc(8);
        n_cmp++; if (dac_out !== 20'h12345) begin n_mis++; $display("FAIL clr_dac_out: got %h expected %h", dac_out, 20'h12345); end
        ldac = 1'b0;
        wait_cyc(6);
        clr = 1'b0;
        wait_cyc(6);
        n_cmp++; if (dac_out !== 20'h12345) begin n_mis++; $display("FAIL clr_dac_out_hold: got %h expected %h", dac_out, 20'h12345); end
        n_cmp++; if (valid_cnt - v0 !== 1) begin n_mis++; $display("FAIL clr_valid_pulses: got %0d expected %0d", valid_cnt - v0, 1); end
    endtask

    task automatic test_readback();
        logic [31:0] cap;
        write_frame(24'h900000);
        n_cmp++; if (dac_reg !== 20'hABCDE) begin n_mis++; $display("FAIL read_no_write: got %h expected %h", dac_reg, 20'hABCDE); end
        send_bits(32'h000000, 24, cap);
        end_frame();
        n_cmp++; if (cap[23:0] !== 24'h9ABCDE) begin n_mis++; $display("FAIL readback_dac: got %h expected %h", cap[23:0], 24'h9ABCDE); end
        n_cmp++; if (sdo !== 1'b0) begin n_mis++; $display("FAIL readback_cleared: got %b expected %b", sdo, 1'b0); end
        write_frame(24'hB00000);
        send_bits(32'h000000, 24, cap);
        end_frame();
        n_cmp++; if (cap[23:0] !== 24'hB12345) begin n_mis++; $display("FAIL readback_clr: got %h expected %h", cap[23:0], 24'hB12345); end
    endtask

    task automatic test_frame_err();
        logic [31:0] cap;
        int e0;
        e0 = err_cnt;
        send_bits(32'h0AAAAA, 23, cap);
        end_frame();
        n_cmp++; if (err_cnt - e0 !== 1) begin n_mis++; $display("FAIL short_frame_err: got %0d expected %0d", err_cnt - e0, 1); end
        send_bits(32'h0155555, 25, cap);
        end_frame();
        n_cmp++; if (err_cnt - e0 !== 2) begin n_mis++; $display("FAIL long_frame_err: got %0d expected %0d", err_cnt - e0, 2); end
        n_cmp++; if (dac_reg !== 20'hABCDE) begin n_mis++; $display("FAIL err_dac_reg: got %h expected %h", dac_reg, 20'hABCDE); end
        n_cmp++; if (clr_reg !== 20'h12345) begin n_mis++; $display("FAIL err_clr_reg: got %h expected %h", clr_reg, 20'h12345); end
    endtask

    task automatic test_swctrl();
        int v0;
        write_frame(24'h255AA5);
        n_cmp++; if (ctrl_reg !== 20'h55AA5) begin n_mis++; $display("FAIL ctrl_write: got %h expected %h", ctrl_reg, 20'h55AA5); end
        v0 = valid_cnt;
        write_frame(24'h400001);
        n_cmp++; if (dac_out !== 20'hABCDE) begin n_mis++; $display("FAIL sw_ldac_dac_out: got %h expected %h", dac_out, 20'hABCDE); end
        n_cmp++; if (valid_cnt - v0 !== 1) begin n_mis++; $display("FAIL sw_ldac_valid: got %0d expected %0d", valid_cnt - v0, 1); end
        write_frame(24'h400004);
        n_cmp++; if ({dac_reg, ctrl_reg, clr_reg, dac_out} !== 80'h0) begin n_mis++; $display("FAIL sw_reset_regs: got %h expected %h", {dac_reg, ctrl_reg, clr_reg, dac_out}, 80'h0); end
        n_cmp++; if (valid_cnt - v0 !== 2) begin n_mis++; $display("FAIL sw_reset_valid: got %0d expected %0d", valid_cnt - v0, 2); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] cap;
        int e0;
        e0 = err_cnt;
        send_bits(32'h200001, 24, cap);
        sync = 1'b0;
        wait_cyc(1);
        send_bits(32'h300002, 24, cap);
        end_frame();
        n_cmp++; if (ctrl_reg !== 20'h00001) begin n_mis++; $display("FAIL b2b_first: got %h expected %h", ctrl_reg, 20'h00001); end
        n_cmp++; if (clr_reg !== 20'h00002) begin n_mis++; $display("FAIL b2b_second: got %h expected %h", clr_reg, 20'h00002); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_mis++; $display("FAIL b2b_err: got %0d expected %0d", err_cnt - e0, 0); end
    endtask

    task automatic test_rst_midframe();
        logic [31:0] cap;
        int e0;
        e0 = err_cnt;
        send_bits(32'h1FF, 12, cap);
        rst = 1'b1;
        wait_cyc(3);
        sync = 1'b0;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(6);
        n_cmp++; if ({dac_reg, ctrl_reg, clr_reg} !== 60'h0) begin n_mis++; $display("FAIL rst_mid_regs: got %h expected %h", {dac_reg, ctrl_reg, clr_reg}, 60'h0); end
        write_frame(24'h177777);
        n_cmp++; if (dac_reg !== 20'h77777) begin n_mis++; $display("FAIL rst_mid_new_frame: got %h expected %h", dac_reg, 20'h77777); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_mis++; $display("FAIL rst_mid_err: got %0d expected %0d", err_cnt - e0, 0); end
    endtask

    initial begin
        test_reset();
        test_write_ldac();
        test_clr();
        test_readback();
        test_frame_err();
        test_swctrl();
        test_back_to_back();
        test_rst_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
